// File: rtl/layer_sequencer_pkg.sv
// rtl/layer_sequencer_pkg.sv - shared types, default widths and cycle-count helper for layer_sequencer
// Contents:
//   state_t       sequencer state encoding
//   DEF_*         default parameter values
//   layer_cycles  cycles from the start-sampling edge to the done cycle (inclusive), out_ready tied high
package layer_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FETCH = 3'd2,
      ST_DRAIN = 3'd3,
      ST_POOL  = 3'd4,
      ST_WRITE = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   localparam int DEF_IA_ADDR_W  = 11;
   localparam int DEF_WTS_ADDR_W = 4;
   localparam int DEF_CH_W       = 8;
   localparam int DEF_TAP_W      = 4;
   localparam int DEF_ACC_LAT    = 2;

   // Each output channel costs CLEAR + fetches + drain + optional pool + WRITE;
   // the final DONE cycle is added once per layer.
   function automatic int unsigned layer_cycles(input int unsigned taps,
                                                input int unsigned in_ch,
                                                input int unsigned out_ch,
                                                input int unsigned pool,
                                                input int unsigned acc_lat);
      int unsigned per_ch;
      per_ch = 1 + (taps + 1) * (in_ch + 1) + acc_lat + pool + 1;
      return (out_ch + 1) * per_ch + 1;
   endfunction

endpackage

// File: rtl/layer_sequencer_valid_delay_line.sv
// rtl/layer_sequencer_valid_delay_line.sv - fixed-depth valid shift register with synchronous flush
// Ports:
//   clock    system clock
//   flush_n  synchronous active-low flush, clears every stage
//   din      valid in
//   dout     din delayed by exactly DEPTH cycles
module valid_delay_line #(
   parameter int DEPTH = 2
) (
   input  logic clock,
   input  logic flush_n,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] stage;

   always_ff @(posedge clock) begin
      if (!flush_n) begin
         stage <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - out-channel / in-channel / tap loop sequencer for the convolution datapath
// Ports:
//   clock, reset           clock and synchronous active-low reset
//   start                  layer start pulse, honoured only in IDLE
//   cfg_*                  layer configuration, captured on start
//   busy, done             layer status towards the top-level controller
//   wts_en, wts_addr       weight BRAM fetch
//   ia_en, ia_addr         input-activation RAM fetch
//   acc_reset, acc_en      accumulator clear / enable (enable trails fetch by ACC_LAT)
//   pool_en                average-pool strobe
//   out_valid, out_ready   per-output-channel write-back handshake
//   out_ch                 current output-channel index
module layer_sequencer
   import layer_sequencer_pkg::*;
#(
   parameter int IA_ADDR_W  = DEF_IA_ADDR_W,
   parameter int WTS_ADDR_W = DEF_WTS_ADDR_W,
   parameter int CH_W       = DEF_CH_W,
   parameter int TAP_W      = DEF_TAP_W,
   parameter int ACC_LAT    = DEF_ACC_LAT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [TAP_W-1:0]      cfg_taps,
   input  logic [CH_W-1:0]       cfg_in_ch,
   input  logic [CH_W-1:0]       cfg_out_ch,
   input  logic                  cfg_pool,
   input  logic [IA_ADDR_W-1:0]  cfg_ia_base,
   input  logic [IA_ADDR_W-1:0]  cfg_ia_stride,
   output logic                  busy,
   output logic                  done,
   output logic                  wts_en,
   output logic [WTS_ADDR_W-1:0] wts_addr,
   output logic                  ia_en,
   output logic [IA_ADDR_W-1:0]  ia_addr,
   output logic                  acc_reset,
   output logic                  acc_en,
   output logic                  pool_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CH_W-1:0]       out_ch
);

   localparam int DRAIN_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

   state_t                 state;
   logic [TAP_W-1:0]       sh_taps;
   logic [CH_W-1:0]        sh_in_ch;
   logic [CH_W-1:0]        sh_out_ch;
   logic                   sh_pool;
   logic [IA_ADDR_W-1:0]   sh_base;
   logic [IA_ADDR_W-1:0]   sh_stride;

   logic [TAP_W-1:0]       tap;
   logic [CH_W-1:0]        ic;
   logic [CH_W-1:0]        oc;
   logic [IA_ADDR_W-1:0]   ic_base;
   // ia_ptr always equals ic_base + tap, kept as its own register so the
   // address output comes straight from a flop.
   logic [IA_ADDR_W-1:0]   ia_ptr;
   logic [WTS_ADDR_W-1:0]  wts_cnt;
   logic [DRAIN_W-1:0]     drain_cnt;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= ST_IDLE;
         sh_taps   <= '0;
         sh_in_ch  <= '0;
         sh_out_ch <= '0;
         sh_pool   <= 1'b0;
         sh_base   <= '0;
         sh_stride <= '0;
         tap       <= '0;
         ic        <= '0;
         oc        <= '0;
         ic_base   <= '0;
         ia_ptr    <= '0;
         wts_cnt   <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sh_taps   <= cfg_taps;
                  sh_in_ch  <= cfg_in_ch;
                  sh_out_ch <= cfg_out_ch;
                  sh_pool   <= cfg_pool;
                  sh_base   <= cfg_ia_base;
                  sh_stride <= cfg_ia_stride;
                  oc        <= '0;
                  wts_cnt   <= '0;
                  state     <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               tap     <= '0;
               ic      <= '0;
               ic_base <= sh_base;
               ia_ptr  <= sh_base;
               state   <= ST_FETCH;
            end
            ST_FETCH: begin
               wts_cnt <= wts_cnt + WTS_ADDR_W'(1);
               if (tap == sh_taps) begin
                  tap     <= '0;
                  ic      <= ic + CH_W'(1);
                  ic_base <= ic_base + sh_stride;
                  ia_ptr  <= ic_base + sh_stride;
                  if (ic == sh_in_ch) begin
                     drain_cnt <= '0;
                     state     <= ST_DRAIN;
                  end
               end else begin
                  tap    <= tap + TAP_W'(1);
                  ia_ptr <= ia_ptr + IA_ADDR_W'(1);
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == DRAIN_W'(ACC_LAT - 1)) begin
                  state <= sh_pool ? ST_POOL : ST_WRITE;
               end else begin
                  drain_cnt <= drain_cnt + DRAIN_W'(1);
               end
            end
            ST_POOL: begin
               state <= ST_WRITE;
            end
            ST_WRITE: begin
               if (out_ready) begin
                  if (oc == sh_out_ch) begin
                     state <= ST_DONE;
                  end else begin
                     oc    <= oc + CH_W'(1);
                     state <= ST_CLEAR;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Moore decode of the registered state and counters.
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign ia_en     = (state == ST_FETCH);
   assign wts_en    = (state == ST_FETCH);
   assign acc_reset = (state == ST_CLEAR);
   assign pool_en   = (state == ST_POOL);
   assign out_valid = (state == ST_WRITE);
   assign ia_addr   = ia_ptr;
   assign wts_addr  = wts_cnt;
   assign out_ch    = oc;

   valid_delay_line #(
      .DEPTH (ACC_LAT)
   ) u_acc_delay (
      .clock   (clock),
      .flush_n (reset),
      .din     (state == ST_FETCH),
      .dout    (acc_en)
   );

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - directed self-checking bench for layer_sequencer against a trace model
`timescale 1ns/1ps
module tb_layer_sequencer;
   import layer_sequencer_pkg::*;

   localparam int IA_W  = 11;
   localparam int WT_W  = 4;
   localparam int CW    = 8;
   localparam int TW    = 4;
   localparam int LAT   = 2;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic [TW-1:0]   cfg_taps = '0;
   logic [CW-1:0]   cfg_in_ch = '0;
   logic [CW-1:0]   cfg_out_ch = '0;
   logic            cfg_pool = 1'b0;
   logic [IA_W-1:0] cfg_ia_base = '0;
   logic [IA_W-1:0] cfg_ia_stride = '0;
   logic            out_ready = 1'b1;
   logic            busy, done, wts_en, ia_en, acc_reset, acc_en, pool_en, out_valid;
   logic [WT_W-1:0] wts_addr;
   logic [IA_W-1:0] ia_addr;
   logic [CW-1:0]   out_ch;

   layer_sequencer #(
      .IA_ADDR_W(IA_W), .WTS_ADDR_W(WT_W), .CH_W(CW), .TAP_W(TW), .ACC_LAT(LAT)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .cfg_taps(cfg_taps), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
      .cfg_pool(cfg_pool), .cfg_ia_base(cfg_ia_base), .cfg_ia_stride(cfg_ia_stride),
      .busy(busy), .done(done), .wts_en(wts_en), .wts_addr(wts_addr),
      .ia_en(ia_en), .ia_addr(ia_addr), .acc_reset(acc_reset), .acc_en(acc_en),
      .pool_en(pool_en), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
   );

   always #5 clock = ~clock;

   typedef struct {
      int busy, done, fetch, acc_reset, acc_en, pool_en, out_valid;
      int ia_addr, wts_addr, out_ch;
   } exp_t;

   exp_t exp_a[$];
   int   rdy_a[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   mode = 0;
   int   idx = 0;
   int   ia_obs[$];
   int   wts_obs[$];
   int   rst_cnt, pool_cnt, done_at, acc_cnt, first_acc, first_ia;

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, idx, act, req);
      end
   endtask

   // Expected per-cycle trace built straight from the loop-nest rules.
   task automatic push(input exp_t e, input int rdy);
      exp_a.push_back(e);
      rdy_a.push_back(rdy);
   endtask

   task automatic build(input int taps, input int in_ch, input int oc_n, input int pool,
                        input int base, input int stride, input int stall_ch, input int stall_n);
      exp_t e;
      exp_t tmp;
      int   w;
      exp_a.delete();
      rdy_a.delete();
      w = 0;
      for (int oc = 0; oc <= oc_n; oc++) begin
         e = '{default:0}; e.busy = 1; e.out_ch = oc; e.acc_reset = 1;
         push(e, 1);
         for (int ic = 0; ic <= in_ch; ic++) begin
            for (int tp = 0; tp <= taps; tp++) begin
               e = '{default:0}; e.busy = 1; e.out_ch = oc; e.fetch = 1;
               e.ia_addr  = (base + ic * stride + tp) % (1 << IA_W);
               e.wts_addr = w % (1 << WT_W);
               w++;
               push(e, 1);
            end
         end
         for (int d = 0; d < LAT; d++) begin
            e = '{default:0}; e.busy = 1; e.out_ch = oc;
            push(e, 1);
         end
         if (pool != 0) begin
            e = '{default:0}; e.busy = 1; e.out_ch = oc; e.pool_en = 1;
            push(e, 1);
         end
         e = '{default:0}; e.busy = 1; e.out_ch = oc; e.out_valid = 1;
         if (oc == stall_ch) begin
            for (int s = 0; s < stall_n; s++) push(e, 0);
         end
         push(e, 1);
      end
      e = '{default:0}; e.busy = 1; e.done = 1; e.out_ch = oc_n;
      push(e, 1);
      for (int t = LAT; t < exp_a.size(); t++) begin
         tmp = exp_a[t];
         tmp.acc_en = exp_a[t-LAT].fetch;
         exp_a[t] = tmp;
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (mode == 1) begin
         e = exp_a[idx];
         chk("busy", int'(busy), e.busy);
         chk("done", int'(done), e.done);
         chk("ia_en", int'(ia_en), e.fetch);
         chk("wts_en", int'(wts_en), e.fetch);
         chk("acc_reset", int'(acc_reset), e.acc_reset);
         chk("acc_en", int'(acc_en), e.acc_en);
         chk("pool_en", int'(pool_en), e.pool_en);
         chk("out_valid", int'(out_valid), e.out_valid);
         if (e.fetch != 0) begin
            chk("ia_addr", int'(ia_addr), e.ia_addr);
            chk("wts_addr", int'(wts_addr), e.wts_addr);
         end
         if (e.busy != 0) chk("out_ch", int'(out_ch), e.out_ch);
         if (ia_en) begin
            if (first_ia < 0) first_ia = idx;
            ia_obs.push_back(int'(ia_addr));
            wts_obs.push_back(int'(wts_addr));
         end
         if (acc_en) begin
            if (first_acc < 0) first_acc = idx;
            acc_cnt++;
         end
         if (acc_reset) rst_cnt++;
         if (pool_en) pool_cnt++;
         if (done) done_at = idx;
      end else if (mode == 2 || mode == 3) begin
         chk("idle_busy", int'(busy), 0);
         chk("idle_done", int'(done), 0);
         chk("idle_ia_en", int'(ia_en), 0);
         chk("idle_wts_en", int'(wts_en), 0);
         chk("idle_acc_reset", int'(acc_reset), 0);
         chk("idle_acc_en", int'(acc_en), 0);
         chk("idle_pool_en", int'(pool_en), 0);
         chk("idle_out_valid", int'(out_valid), 0);
         if (mode == 2) begin
            chk("rst_ia_addr", int'(ia_addr), 0);
            chk("rst_wts_addr", int'(wts_addr), 0);
            chk("rst_out_ch", int'(out_ch), 0);
         end
      end
   end

   task automatic run_layer(input int taps, input int in_ch, input int oc_n, input int pool,
                            input int base, input int stride, input int stall_ch, input int stall_n,
                            input int busy_start_at, input int abort_at);
      build(taps, in_ch, oc_n, pool, base, stride, stall_ch, stall_n);
      if (stall_n == 0 && abort_at < 0)
         chk("model_len", exp_a.size(),
             int'(layer_cycles(taps, in_ch, oc_n, pool, LAT)));
      ia_obs.delete(); wts_obs.delete();
      rst_cnt = 0; pool_cnt = 0; done_at = -1; acc_cnt = 0; first_acc = -1; first_ia = -1;
      cfg_taps = TW'(taps); cfg_in_ch = CW'(in_ch); cfg_out_ch = CW'(oc_n);
      cfg_pool = pool[0]; cfg_ia_base = IA_W'(base); cfg_ia_stride = IA_W'(stride);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      cfg_taps = TW'($urandom); cfg_in_ch = CW'($urandom); cfg_out_ch = CW'($urandom);
      cfg_pool = 1'($urandom); cfg_ia_base = IA_W'($urandom); cfg_ia_stride = IA_W'($urandom);
      mode = 1;
      for (int t = 0; t < exp_a.size(); t++) begin
         idx = t;
         out_ready = rdy_a[t][0];
         start = (t == busy_start_at);
         if (t == abort_at) reset = 1'b0;
         @(posedge clock); #1;
         if (t == abort_at) begin
            reset = 1'b1;
            start = 1'b0;
            mode  = 2;
            repeat (3) begin
               @(posedge clock); #1;
            end
            mode = 0;
            out_ready = 1'b1;
            return;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      mode = 3;
      @(posedge clock); #1;
      mode = 0;
   endtask

   task automatic pin_scenario1();
      int exp_ia[4];
      exp_ia = '{100, 101, 116, 117};
      chk("s1_done_latency", done_at + 1, 9);
      chk("s1_fetch_count", ia_obs.size(), 4);
      chk("s1_acc_en_offset", first_acc - first_ia, 2);
      chk("s1_acc_en_len", acc_cnt, 4);
      if (ia_obs.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("s1_ia_addr", ia_obs[i], exp_ia[i]);
            chk("s1_wts_addr", wts_obs[i], i);
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      @(posedge clock); #1;
      mode = 2;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      mode = 0;

      // zero config: single fetch, single output
      run_layer(0, 0, 0, 0, 5, 3, -1, 0, -1, -1);
      chk("s0_done_latency", done_at + 1, 6);
      chk("s0_fetch_count", ia_obs.size(), 1);
      if (ia_obs.size() == 1) chk("s0_ia_addr", ia_obs[0], 5);

      run_layer(1, 1, 0, 0, 100, 16, -1, 0, -1, -1);
      pin_scenario1();

      run_layer(1, 1, 2, 0, 100, 16, -1, 0, -1, -1);
      chk("s2_acc_reset_pulses", rst_cnt, 3);
      chk("s2_fetch_count", ia_obs.size(), 12);
      if (ia_obs.size() == 12) begin
         chk("s2_wts_last", wts_obs[11], 11);
         chk("s2_ia_repeat1", ia_obs[4], 100);
         chk("s2_ia_repeat2", ia_obs[8], 100);
      end

      run_layer(1, 1, 1, 0, 100, 16, 0, 5, -1, -1);
      chk("s3_stall_done_latency", done_at + 1, 22);

      run_layer(1, 1, 1, 1, 100, 16, -1, 0, -1, -1);
      chk("s4_pool_pulses", pool_cnt, 2);
      chk("s4_done_latency", done_at + 1, 19);

      run_layer(3, 4, 0, 0, 2040, 8, -1, 0, -1, -1);
      chk("s5_fetch_count", ia_obs.size(), 20);
      if (ia_obs.size() == 20) begin
         for (int i = 0; i < 4; i++) begin
            chk("s5_ia_high", ia_obs[i], 2040 + i);
            chk("s5_ia_wrap", ia_obs[4+i], i);
         end
         chk("s5_wts_15", wts_obs[15], 15);
         chk("s5_wts_wrap", wts_obs[16], 0);
      end

      run_layer(1, 1, 2, 0, 100, 16, -1, 0, 2, 4);
      chk("s6_no_done_on_abort", done_at, -1);

      run_layer(1, 1, 0, 0, 100, 16, -1, 0, -1, -1);
      pin_scenario1();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Parametrised layer-loop sequencer for the convolution datapath; next generation of the fixed control system. Walks a runtime-configured out-channel / in-channel / kernel-tap loop nest, issuing weight and input-activation fetch addresses, accumulator clear and enable strobes with configurable pipeline latency, an optional average-pool phase, and a ready/valid write-back handshake per output channel. Sits between the top-level controller (start/done) and the Frontend/Backend strobes.

Parameters:
IA_ADDR_W, 11, input-activation RAM address width
WTS_ADDR_W, 4, weight BRAM address width
CH_W, 8, width of channel counters and configs
TAP_W, 4, width of tap counter and config
ACC_LAT, 2, cycles from fetch issue to accumulator enable (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  layer start pulse; sampled only in IDLE
cfg_taps  in  TAP_W  kernel taps minus one
cfg_in_ch  in  CH_W  input channels minus one
cfg_out_ch  in  CH_W  output channels minus one
cfg_pool  in  1  insert POOL phase per output channel
cfg_ia_base  in  IA_ADDR_W  first IA address
cfg_ia_stride  in  IA_ADDR_W  IA address step per input channel
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at layer completion
wts_en  out  1  weight BRAM read enable
wts_addr  out  WTS_ADDR_W  weight BRAM address
ia_en  out  1  IA RAM read enable
ia_addr  out  IA_ADDR_W  IA RAM address
acc_reset  out  1  accumulator clear
acc_en  out  1  accumulator enable
pool_en  out  1  average-pool strobe
out_valid  out  1  result for out_ch ready
out_ready  in  1  write-back sink ready
out_ch  out  CH_W  current output-channel index

Behaviour:
- Reset (reset==0 at rising edge): state IDLE; all outputs 0; all counters 0; ACC_LAT delay line flushed. Takes priority over all events, including mid-layer: the layer is abandoned without a done pulse.
- All outputs registered (Moore, decoded from the registered state and counters).
- IDLE: start==1 latches all cfg_* into shadow registers; next cycle is CLEAR. cfg_* changes after latch have no effect. start in any other state is ignored.
- CLEAR: exactly 1 cycle, acc_reset=1; tap=0, ic=0, ic_base=cfg_ia_base; go to FETCH.
- FETCH: one fetch per cycle; ia_en=wts_en=1; ia_addr=(ic_base+tap) mod 2^IA_ADDR_W; wts_addr = running counter, 0 at layer start, +1 per fetch, wraps mod 2^WTS_ADDR_W and is never reset between output channels. tap increments; at tap==cfg_taps, tap=0, ic+1, ic_base+=cfg_ia_stride (mod 2^IA_ADDR_W). After the fetch with tap==cfg_taps && ic==cfg_in_ch, go to DRAIN. FETCH length = (cfg_taps+1)*(cfg_in_ch+1) cycles.
- acc_en = ia_en delayed by exactly ACC_LAT cycles (shift register), asserted for the same number of cycles.
- DRAIN: exactly ACC_LAT cycles, no fetches; then POOL if cfg_pool, else WRITE. The last acc_en occurs in the final DRAIN cycle.
- POOL: 1 cycle, pool_en=1; go to WRITE.
- WRITE: out_valid=1, held with out_ch stable until out_valid&&out_ready. On handshake: if out_ch==cfg_out_ch go to DONE, else out_ch+1 and go to CLEAR.
- DONE: done=1 for 1 cycle; go to IDLE. busy drops in the IDLE cycle.
- Per-output-channel cycles with out_ready tied high = 1 + N_fetch + ACC_LAT + cfg_pool + 1.
- Zero configs are legal: cfg_taps=cfg_in_ch=cfg_out_ch=0 gives a single fetch and a single output.

Decomposition:
- Shared package: state enum (IDLE, CLEAR, FETCH, DRAIN, POOL, WRITE, DONE), default width localparams, cycle-count helper function used by the testbench.
- One sub-module: valid_delay_line (parameter DEPTH=ACC_LAT; synchronous active-low flush), which generates acc_en.

Test Plan:
- taps=1, in_ch=1, out_ch=0, base=100, stride=16, pool=0, ACC_LAT=2, ready=1 -> ia_addr 100,101,116,117; wts_addr 0..3; acc_en high 4 cycles starting 2 cycles after first ia_en; done exactly 9 cycles after start sampled.
- Same config with out_ch=2 -> 3 acc_reset pulses; wts_addr continues 4..11 without reset; IA addresses repeat from 100 for each out_ch; out_ch values 0,1,2.
- out_ready held low 5 cycles in WRITE -> out_valid stays high, out_ch stable, no fetches issued; proceeds the cycle after out_ready rises.
- cfg_pool=1 -> one pool_en pulse per output channel, in the cycle after the final DRAIN cycle and before out_valid.
- base=2040, stride=8, taps=3, IA_ADDR_W=11 -> ia_addr wraps 2040..2043, 0..3; wts_addr wraps 15->0 on long layer.
- reset low mid-FETCH, plus start pulsed while busy -> outputs 0 next cycle, no done pulse; busy start ignored; fresh start behaves as in scenario 1.
